// File: rtl/cmp_share_sched_if.sv
// Bundle between the requesters, the scheduler and the shared equality comparator.
// The scheduler takes the slave side; requesters plus comparator sit on the master side.
interface cmp_share_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [W-1:0]      cmp_a;
  logic [W-1:0]      cmp_b;
  logic              cmp_eq;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   match;
  logic              busy;
  logic [NREQ-1:0]   grant;

  modport master (
    output req, a_in, b_in, cmp_eq,
    input  cmp_a, cmp_b, done, match, busy, grant
  );

  modport slave (
    input  req, a_in, b_in, cmp_eq,
    output cmp_a, cmp_b, done, match, busy, grant
  );
endinterface

// File: rtl/cmp_share_sched.sv
// Round-robin scheduler sharing one external W-bit equality comparator among NREQ requesters.
// Two-state FSM: IDLE loads the chosen operands, EVAL samples cmp_eq and retires the grant.
module cmp_share_sched #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input logic              clk,
  input logic              rst_n,
  cmp_share_sched_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_IDLE, ST_EVAL} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_owner;
  logic [W-1:0]    r_cmp_a;
  logic [W-1:0]    r_cmp_b;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] r_match;
  logic [NREQ-1:0] r_grant;
  logic            r_busy;

  logic [NREQ-1:0] w_eligible;
  logic [W-1:0]    w_a_arr [NREQ];
  logic [W-1:0]    w_b_arr [NREQ];
  logic [PW-1:0]   w_scan  [NREQ];
  logic [NREQ-1:0] w_onehot;
  logic [PW-1:0]   w_pick;
  logic            w_found;

  // A requester whose done is showing this cycle may still be holding req; skip it once.
  assign w_eligible = bus.req & ~r_done;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      assign w_a_arr[gi]  = bus.a_in[gi*W +: W];
      assign w_b_arr[gi]  = bus.b_in[gi*W +: W];
      assign w_scan[gi]   = (int'(r_rr_ptr) + gi >= NREQ) ? PW'(int'(r_rr_ptr) + gi - NREQ)
                                                          : PW'(int'(r_rr_ptr) + gi);
      assign w_onehot[gi] = (w_pick == PW'(gi));
    end
  endgenerate

  // Scan from the far end so the slot closest to rr_ptr is the one left standing.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_eligible[w_scan[k]]) begin
        w_found = 1'b1;
        w_pick  = w_scan[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_cmp_a  <= '0;
      r_cmp_b  <= '0;
      r_done   <= '0;
      r_match  <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_cmp_a <= w_a_arr[w_pick];
            r_cmp_b <= w_b_arr[w_pick];
            r_owner <= w_pick;
            r_grant <= w_onehot;
            r_busy  <= 1'b1;
            r_state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          // A withdrawn request is dropped silently and keeps its place in the rotation.
          if (bus.req[r_owner]) begin
            r_done           <= r_grant;
            r_match[r_owner] <= bus.cmp_eq;
            r_rr_ptr         <= (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
          end
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmp_a = r_cmp_a;
  assign bus.cmp_b = r_cmp_b;
  assign bus.done  = r_done;
  assign bus.match = r_match;
  assign bus.grant = r_grant;
  assign bus.busy  = r_busy;
endmodule
